// File: rtl/fb_pkg.sv
// Shared constants and types for the double-buffered frame buffer controller.
package fb_pkg;

  localparam int unsigned RENDER_W    = 320;
  localparam int unsigned RENDER_H    = 180;
  localparam int unsigned BANK_DEPTH  = RENDER_W * RENDER_H;
  localparam logic [15:0] BLANK_PIXEL = '0;

  typedef enum logic {
    WRITING   = 1'b0,
    SWAP_WAIT = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_bram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module fb_bram
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = BANK_DEPTH,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame buffer: ray stream fills the back bank, display reads
// the front bank upscaled 4x, banks swap at the first frame boundary after a full sweep.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH        = 16,
  parameter int unsigned FULL_SCREEN_WIDTH  = 1280,
  parameter int unsigned FULL_SCREEN_HEIGHT = 720,
  parameter int unsigned SCREEN_WIDTH       = 320,
  parameter int unsigned SCREEN_HEIGHT      = 180
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic                   ray_valid_in,
  input  logic [15:0]            ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_pixel_in,
  output logic                   ray_ready_out,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   new_frame_in,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   display_bank_out,
  output logic                   swap_pending_out,
  output logic [7:0]             frame_count_out,
  output logic                   addr_err_out
);

  localparam int unsigned DEPTH = SCREEN_WIDTH * SCREEN_HEIGHT;

  fb_state_t state_q, state_d;
  logic       bank_q;
  logic [7:0] count_q;
  logic       err_q;
  logic       accept, in_range, do_swap;
  logic       we0, we1;

  logic [15:0] h_cell, v_cell, rd_addr_d, rd_addr_q;
  logic        active_d, active1_q, active2_q, bank1_q, bank2_q;
  logic [PIXEL_WIDTH-1:0] rdata0, rdata1;

  // Ready is gated by reset so it reads low while reset is held.
  assign ray_ready_out = rst_n_in && (state_q == WRITING);
  assign accept        = ray_valid_in && ray_ready_out;
  assign in_range      = 32'(ray_address_in) < DEPTH;

  assign display_bank_out = bank_q;
  assign swap_pending_out = (state_q == SWAP_WAIT);
  assign frame_count_out  = count_q;
  assign addr_err_out     = err_q;

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      WRITING:   if (accept && ray_last_pixel_in) state_d = SWAP_WAIT;
      SWAP_WAIT: if (new_frame_in) begin
        state_d = WRITING;
        do_swap = 1'b1;
      end
      default:   state_d = WRITING;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= WRITING;
      bank_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_swap) begin
        bank_q  <= ~bank_q;
        count_q <= count_q + 8'd1;
      end
      if (accept && !in_range) err_q <= 1'b1;
    end
  end

  assign we0 = accept && in_range && bank_q;
  assign we1 = accept && in_range && !bank_q;

  // Row offset v*320 built as (v<<8)+(v<<6); truncation only affects blanked reads.
  assign h_cell    = 16'(hcount_in >> 2);
  assign v_cell    = 16'(vcount_in >> 2);
  assign rd_addr_d = h_cell + (v_cell << 8) + (v_cell << 6);
  assign active_d  = (32'(hcount_in) < FULL_SCREEN_WIDTH) &&
                     (32'(vcount_in) < FULL_SCREEN_HEIGHT);

  // Bank and active flag travel with the address so a read never mixes banks.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_addr_q <= '0;
      active1_q <= 1'b0;
      bank1_q   <= 1'b0;
      active2_q <= 1'b0;
      bank2_q   <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      active1_q <= active_d;
      bank1_q   <= bank_q;
      active2_q <= active1_q;
      bank2_q   <= bank1_q;
    end
  end

  fb_bram #(.DEPTH(DEPTH), .WIDTH(PIXEL_WIDTH), .AW(16)) u_bank0 (
    .clk   (pixel_clk_in),
    .we    (we0),
    .waddr (ray_address_in),
    .wdata (ray_pixel_in),
    .raddr (rd_addr_q),
    .rdata (rdata0)
  );

  fb_bram #(.DEPTH(DEPTH), .WIDTH(PIXEL_WIDTH), .AW(16)) u_bank1 (
    .clk   (pixel_clk_in),
    .we    (we1),
    .waddr (ray_address_in),
    .wdata (ray_pixel_in),
    .raddr (rd_addr_q),
    .rdata (rdata1)
  );

  always_comb begin
    pixel_out = PIXEL_WIDTH'(BLANK_PIXEL);
    if (active2_q) pixel_out = bank2_q ? rdata1 : rdata0;
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl: sweep, swap rules, read pipeline, address errors, reset.
module tb_frame_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] addr;
  logic [15:0] pix;
  logic        last;
  logic        ready;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        new_frame;
  logic [15:0] pixel_out;
  logic        bank;
  logic        pending;
  logic [7:0]  fcount;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_buffer_ctrl #(
    .PIXEL_WIDTH(16), .FULL_SCREEN_WIDTH(1280), .FULL_SCREEN_HEIGHT(720),
    .SCREEN_WIDTH(320), .SCREEN_HEIGHT(180)
  ) dut (
    .pixel_clk_in      (clk),
    .rst_n_in          (rst_n),
    .ray_valid_in      (valid),
    .ray_address_in    (addr),
    .ray_pixel_in      (pix),
    .ray_last_pixel_in (last),
    .ray_ready_out     (ready),
    .hcount_in         (hcount),
    .vcount_in         (vcount),
    .new_frame_in      (new_frame),
    .pixel_out         (pixel_out),
    .display_bank_out  (bank),
    .swap_pending_out  (pending),
    .frame_count_out   (fcount),
    .addr_err_out      (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] p, input logic l);
    valid = 1'b1; addr = a; pix = p; last = l;
    step();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic rd(input logic [10:0] h, input logic [9:0] v, input string tag,
                    input logic [31:0] exp);
    hcount = h; vcount = v;
    step();
    step();
    chk(tag, 32'(pixel_out), exp);
  endtask

  task automatic pulse_nf();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; addr = '0; pix = '0; last = 1'b0;
    hcount = '0; vcount = '0; new_frame = 1'b0;
    #12;
    chk("rst_ready",   32'(ready),     32'd0);
    chk("rst_pixel",   32'(pixel_out), 32'd0);
    chk("rst_bank",    32'(bank),      32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    chk("rst_count",   32'(fcount),    32'd0);
    chk("rst_err",     32'(err),       32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(ready), 32'd1);

    // partial sweep then a frame boundary: must be ignored
    for (int i = 0; i < 100; i++) wr(16'(i), 16'(i), 1'b0);
    pulse_nf();
    chk("partial_bank",    32'(bank),    32'd0);
    chk("partial_count",   32'(fcount),  32'd0);
    chk("partial_ready",   32'(ready),   32'd1);
    chk("partial_pending", 32'(pending), 32'd0);

    // full sweep, value = address
    for (int i = 0; i < 57600; i++) begin
      valid = 1'b1; addr = 16'(i); pix = 16'(i); last = (i == 57599);
      step();
    end
    valid = 1'b0; last = 1'b0;
    chk("sweep_ready",   32'(ready),   32'd0);
    chk("sweep_pending", 32'(pending), 32'd1);
    chk("sweep_bank",    32'(bank),    32'd0);

    // writes held off in SWAP_WAIT
    valid = 1'b1; addr = 16'd5; pix = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("swapwait_ready", 32'(ready), 32'd0);
    end
    valid = 1'b0;
    pulse_nf();
    chk("swap1_ready",   32'(ready),   32'd1);
    chk("swap1_bank",    32'(bank),    32'd1);
    chk("swap1_count",   32'(fcount),  32'd1);
    chk("swap1_pending", 32'(pending), 32'd0);
    rd(11'd8,    10'd4,   "rd_322",    32'd322);
    rd(11'd20,   10'd0,   "rd_addr5",  32'd5);
    rd(11'd1279, 10'd719, "rd_corner", 32'd57599);
    rd(11'd1280, 10'd0,   "rd_hblank", 32'd0);
    rd(11'd0,    10'd720, "rd_vblank", 32'd0);

    // last pixel coincident with new_frame: no swap yet
    wr(16'd0, 16'h1111, 1'b0);
    valid = 1'b1; addr = 16'd1; pix = 16'h2222; last = 1'b1; new_frame = 1'b1;
    step();
    valid = 1'b0; last = 1'b0; new_frame = 1'b0;
    chk("coinc_pending", 32'(pending), 32'd1);
    chk("coinc_bank",    32'(bank),    32'd1);
    chk("coinc_count",   32'(fcount),  32'd1);
    chk("coinc_ready",   32'(ready),   32'd0);
    step();
    pulse_nf();
    chk("swap2_bank",    32'(bank),    32'd0);
    chk("swap2_count",   32'(fcount),  32'd2);
    chk("swap2_pending", 32'(pending), 32'd0);
    rd(11'd0, 10'd0, "rd_b0_a0", 32'h1111);
    rd(11'd4, 10'd0, "rd_b0_a1", 32'h2222);

    // address range boundary and sticky error
    wr(16'd57599, 16'h5555, 1'b0);
    chk("err_at_57599", 32'(err), 32'd0);
    wr(16'd57600, 16'h6666, 1'b0);
    chk("err_at_57600", 32'(err), 32'd1);
    wr(16'd60000, 16'hBEEF, 1'b1);
    chk("err_60000",         32'(err),     32'd1);
    chk("err_last_pending",  32'(pending), 32'd1);
    step(); step(); step();
    chk("err_sticky", 32'(err), 32'd1);
    pulse_nf();
    chk("swap3_bank",  32'(bank),   32'd1);
    chk("swap3_count", 32'(fcount), 32'd3);
    rd(11'd1279, 10'd719, "rd_b1_57599", 32'h5555);
    rd(11'd8,    10'd4,   "rd_b1_322",   32'd322);

    // asynchronous reset while in SWAP_WAIT
    wr(16'd10, 16'h0A0A, 1'b1);
    chk("pre_rst_pending", 32'(pending),   32'd1);
    chk("pre_rst_pixel",   32'(pixel_out), 32'd322);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",   32'(ready),     32'd0);
    chk("arst_pending", 32'(pending),   32'd0);
    chk("arst_bank",    32'(bank),      32'd0);
    chk("arst_count",   32'(fcount),    32'd0);
    chk("arst_err",     32'(err),       32'd0);
    chk("arst_pixel",   32'(pixel_out), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("arst_release_ready", 32'(ready), 32'd1);

    // asynchronous reset mid-sweep
    wr(16'd100, 16'h0100, 1'b0);
    wr(16'd60000, 16'h0000, 1'b0);
    chk("mid_err_set", 32'(err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_err",   32'(err),   32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    #2 rst_n = 1'b1;
    step();
    wr(16'd2, 16'h0002, 1'b1);
    chk("post_rst_pending", 32'(pending), 32'd1);
    chk("post_rst_count",   32'(fcount),  32'd0);
    chk("post_rst_bank",    32'(bank),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Double-buffered frame buffer controller downstream of the transformation stage. It accepts the flattened ray pixel stream (address, pixel, last-pixel flag) into a back buffer of SCREEN_WIDTH×SCREEN_HEIGHT 16-bit pixels. It swaps buffers at the next frame boundary once a full sweep has been written. It serves the display pipeline with pixels upscaled 4× to FULL_SCREEN_WIDTH×FULL_SCREEN_HEIGHT.

## Interface
Parameters:
- PIXEL_WIDTH, 16: bits per stored pixel
- FULL_SCREEN_WIDTH, 1280: display active width
- FULL_SCREEN_HEIGHT, 720: display active height
- SCREEN_WIDTH, 320: render width; FULL_SCREEN_WIDTH/4
- SCREEN_HEIGHT, 180: render height; FULL_SCREEN_HEIGHT/4

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - pixel_clk_in  in  1  sole clock
  - rst_n_in  in  1  asynchronous, active-low reset
- Write side (from the transformation stage):
  - ray_valid_in  in  1  ray_address_in/ray_pixel_in/ray_last_pixel_in valid this cycle
  - ray_address_in  in  16  back-buffer address, 0..SCREEN_WIDTH*SCREEN_HEIGHT-1
  - ray_pixel_in  in  16  pixel value
  - ray_last_pixel_in  in  1  final pixel of the sweep
  - ray_ready_out  out  1  write accepted when high with ray_valid_in
- Read side (from video timing):
  - hcount_in  in  11  display x
  - vcount_in  in  10  display y
  - new_frame_in  in  1  one-cycle pulse at start of vertical blanking
  - pixel_out  out  16  display pixel, 2-cycle latency
- Status:
  - display_bank_out  out  1  bank currently displayed
  - swap_pending_out  out  1  back buffer complete, waiting for new_frame_in
  - frame_count_out  out  8  completed swaps, wraps 255→0
  - addr_err_out  out  1  sticky: an out-of-range write was dropped

## Operation
- Banks and writes
  - Two banks, each SCREEN_WIDTH*SCREEN_HEIGHT (57600) words. Display bank = display_bank_out; write bank = its complement.
  - Write accept = ray_valid_in && ray_ready_out. The accepted pixel is written to ray_address_in of the write bank.
  - If ray_address_in ≥ 57600: no write, addr_err_out set until reset. ray_last_pixel_in is still honoured.
- State machine
  - WRITING: ray_ready_out=1. An accepted beat with ray_last_pixel_in=1 goes to SWAP_WAIT and sets swap_pending_out.
  - SWAP_WAIT: ray_ready_out=0. On new_frame_in: toggle display_bank_out, increment frame_count_out, clear swap_pending_out, return to WRITING.
  - new_frame_in in WRITING: ignored, no swap. A partially written back buffer is never displayed.
- Simultaneous events
  - Last-pixel accept and new_frame_in in the same cycle: the write completes and the state enters SWAP_WAIT. No swap this cycle; the swap occurs on the next new_frame_in.
- Read address
  - rd_addr = (hcount_in>>2) + (vcount_in>>2)*SCREEN_WIDTH. The multiply is done as (v<<8)+(v<<6), 16-bit result.
  - Active = hcount_in<FULL_SCREEN_WIDTH && vcount_in<FULL_SCREEN_HEIGHT. Outside the active area pixel_out = 0.
  - Bank select and the active flag are pipelined alongside the BRAM read. A swap mid-line therefore never mixes banks within one read.
- Reset
  - Asserting rst_n_in low at any time forces WRITING and clears all status. An in-progress sweep is abandoned.
  - BRAM contents are not cleared.
- Reset values: ray_ready_out=1 after reset release (0 during reset), pixel_out=0, display_bank_out=0, swap_pending_out=0, frame_count_out=0, addr_err_out=0.

## Timing
- Write: accepted at edge N, readable from the BRAM at edge N+1 or later.
- ray_ready_out:
  - Falls the cycle after the last-pixel accept.
  - Rises the cycle after the new_frame_in that performs the swap.
- Read: hcount_in/vcount_in at edge N → pixel_out valid after edge N+2. Stage 1 = address register; stage 2 = BRAM output register, with bank mux and blanking applied at the output.
- display_bank_out toggles at the edge sampling new_frame_in. Reads issued from that edge onward use the new bank.
- Throughput: one write and one read per cycle, with no stalls except SWAP_WAIT.

## Structure
- Shared package fb_pkg: bank-depth constant (SCREEN_WIDTH*SCREEN_HEIGHT), the fb state enum {WRITING, SWAP_WAIT}, and BLANK_PIXEL=0.
- Sub-module fb_bram: simple dual-port RAM (1 write, 1 read), depth and width parameters, registered output. The top level instantiates it twice, one per bank.

## Test plan
- Write 57600 pixels with value = address, last on address 57599, then pulse new_frame_in → display_bank_out=1, frame_count_out=1. hcount=8, vcount=4 gives pixel_out=322 two cycles later.
- new_frame_in during WRITING after 100 pixels → no toggle, frame_count_out stays 0, ray_ready_out stays 1.
- In SWAP_WAIT, hold ray_valid_in for 10 cycles → ray_ready_out=0 and write-bank contents unchanged. After new_frame_in, ready returns the next cycle.
- Last-pixel accept coincident with new_frame_in → swap_pending_out=1, no swap. The swap happens on the next new_frame_in.
- Write to address 60000 → no BRAM write, addr_err_out=1 and held. Read at hcount=1280, vcount=0 → pixel_out=0.
- Assert rst_n_in low mid-sweep and again in SWAP_WAIT → all outputs at their reset values immediately (asynchronous), state WRITING.
